// File: rtl/throw_pkg.sv
// Shared types and default constants for the 2-D throw arc controller.
package throw_pkg;

    localparam int TICK_DIV_DEF = 32;
    localparam int GRAVITY_DEF  = 1;
    localparam int X_MAX_DEF    = 1023;
    localparam int V_W_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_e;

    // Vertical velocity at the default launch width: two extra bits for sign and headroom.
    typedef logic signed [V_W_DEF+1:0] vel_t;

endpackage

// File: rtl/throw_tick_gen.sv
// Motion-step strobe: fires once every TICK_DIV cycles while running, restarted by clear.
module throw_tick_gen #(
    parameter int TICK_DIV = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = run_i && (cnt_q == LAST);

    // Next count: wrap on the last phase, hold at zero when idle or restarting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Phase counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/throw_arc_ctl.sv
// Ballistic sprite arc: y rises/falls under integer gravity, x moves linearly with clamping.
module throw_arc_ctl
    import throw_pkg::*;
#(
    parameter int POS_W    = 12,
    parameter int V_W      = 8,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int GRAVITY  = GRAVITY_DEF,
    parameter int X_MAX    = X_MAX_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             abort_i,
    input  logic [V_W-1:0]   v0_i,
    input  logic [POS_W-1:0] x_start_i,
    input  logic [3:0]       x_speed_i,
    input  logic             dir_i,
    output logic [POS_W-1:0] x_pos_o,
    output logic [POS_W-1:0] y_pos_o,
    output logic             busy_o,
    output logic             at_peak_o,
    output logic             done_o
);

    localparam int VW = V_W + 2;
    localparam int YW = POS_W + 2;
    localparam int XW = POS_W + 1;
    localparam logic signed [VW-1:0] GRAV_S  = VW'(GRAVITY);
    localparam logic [XW-1:0]        X_MAX_X = XW'(X_MAX);
    localparam logic [POS_W-1:0]     X_MAX_P = POS_W'(X_MAX);

    state_e                  state_q, state_d;
    logic [POS_W-1:0]        x_q, x_d, y_q, y_d;
    logic signed [VW-1:0]    vy_q, vy_d;
    logic [3:0]              spd_q, spd_d;
    logic                    dir_q, dir_d;
    logic                    busy_q, busy_d, peak_q, peak_d, done_q, done_d;

    logic                    tick_s, start_s;
    logic signed [YW-1:0]    vy_ext_s, ynew_s;
    logic signed [VW-1:0]    vy_next_s;
    logic [POS_W-1:0]        y_sat_s, x_step_s;
    logic [XW-1:0]           x_sum_s, spd_ext_s;
    logic                    y_land_s, vy_le0_s;

    throw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (start_s),
        .run_i   (busy_q),
        .tick_o  (tick_s)
    );

    assign vy_ext_s  = {{(YW - VW){vy_q[VW-1]}}, vy_q};
    assign ynew_s    = $signed({2'b00, y_q}) + vy_ext_s;
    assign vy_next_s = vy_q - GRAV_S;
    assign y_land_s  = ynew_s[YW-1] || (ynew_s == '0);
    assign vy_le0_s  = vy_next_s[VW-1] || (vy_next_s == '0);
    assign spd_ext_s = XW'(spd_q);
    assign x_sum_s   = {1'b0, x_q} + spd_ext_s;

    // Per-tick candidate positions: y saturated to the top of the field, x clamped to [0, X_MAX].
    always_comb begin
        y_sat_s  = ynew_s[POS_W-1:0];
        x_step_s = x_q;
        if (ynew_s[YW-1]) begin
            y_sat_s = '0;
        end else if (ynew_s[YW-2:POS_W] != 2'b00) begin
            y_sat_s = {POS_W{1'b1}};
        end else begin
            y_sat_s = ynew_s[POS_W-1:0];
        end
        if (dir_q) begin
            if ({1'b0, x_q} < spd_ext_s) begin
                x_step_s = '0;
            end else begin
                x_step_s = x_q - spd_ext_s[POS_W-1:0];
            end
        end else if (x_sum_s > X_MAX_X) begin
            x_step_s = X_MAX_P;
        end else begin
            x_step_s = x_sum_s[POS_W-1:0];
        end
    end

    // Flight FSM: start, abort, and tick-driven rise/fall updates.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        spd_d   = spd_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        peak_d  = 1'b0;
        done_d  = 1'b0;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && !abort_i) begin
                    start_s = 1'b1;
                    state_d = ST_RISE;
                    busy_d  = 1'b1;
                    x_d     = x_start_i;
                    y_d     = '0;
                    vy_d    = {2'b00, v0_i};
                    spd_d   = x_speed_i;
                    dir_d   = dir_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RISE, ST_FALL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    y_d     = '0;
                    vy_d    = '0;
                end else if (tick_s) begin
                    x_d  = x_step_s;
                    vy_d = vy_next_s;
                    // A zero launch velocity turns at the peak and lands on the same tick.
                    if (state_q == ST_RISE && !vy_le0_s) begin
                        y_d = y_sat_s;
                    end else if (y_land_s) begin
                        peak_d  = (state_q == ST_RISE);
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        y_d     = '0;
                    end else begin
                        peak_d  = (state_q == ST_RISE);
                        state_d = ST_FALL;
                        y_d     = y_sat_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vy_q    <= '0;
            spd_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            peak_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            spd_q   <= spd_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            peak_q  <= peak_d;
            done_q  <= done_d;
        end
    end

    assign x_pos_o   = x_q;
    assign y_pos_o   = y_q;
    assign busy_o    = busy_q;
    assign at_peak_o = peak_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_throw_arc_ctl.sv
// Directed bench for throw_arc_ctl with TICK_DIV=4; expectations from closed-form trajectories.
module tb_throw_arc_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  v0 = 8'd0;
    logic [11:0] x_start = 12'd0;
    logic [3:0]  x_speed = 4'd0;
    logic        dir = 1'b0;
    logic [11:0] x_pos, y_pos;
    logic        busy, at_peak, done;

    int n_tests = 0;
    int n_fail  = 0;
    int peak_cnt, done_cnt, busy_cnt, ynz_cnt, ymax;

    throw_arc_ctl #(.POS_W(12), .V_W(8), .TICK_DIV(4), .GRAVITY(1), .X_MAX(1023)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .abort_i(abort),
        .v0_i(v0), .x_start_i(x_start), .x_speed_i(x_speed), .dir_i(dir),
        .x_pos_o(x_pos), .y_pos_o(y_pos), .busy_o(busy), .at_peak_o(at_peak), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic int exp_y(input int v, input int k);
        return k * v - (k * (k - 1)) / 2;
    endfunction

    function automatic int exp_x(input int xs, input int sp, input int d, input int k);
        int r;
        if (d != 0) begin
            r = xs - sp * k;
            if (r < 0) r = 0;
        end else begin
            r = xs + sp * k;
            if (r > 1023) r = 1023;
        end
        return r;
    endfunction

    // Advance one motion step (4 cycles), sampling 1 time unit after each edge.
    task automatic wait_tick();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            enable = 1'b0;
            abort  = 1'b0;
            peak_cnt += int'(at_peak);
            done_cnt += int'(done);
            busy_cnt += int'(busy);
            if (y_pos != 12'd0) ynz_cnt++;
            if (int'(y_pos) > ymax) ymax = int'(y_pos);
        end
    endtask

    task automatic launch(input int v, input int xs, input int sp, input logic d);
        v0 = v[7:0]; x_start = xs[11:0]; x_speed = sp[3:0]; dir = d;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        peak_cnt = 0; done_cnt = 0; ynz_cnt = 0; ymax = 0;
        busy_cnt = int'(busy);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (x_pos !== 12'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", x_pos); end
        n_tests++; if (y_pos !== 12'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", y_pos); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (at_peak !== 1'b0) begin n_fail++; $display("FAIL reset_peak: got %b want 0", at_peak); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_arc();
        launch(13, 100, 2, 1'b0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_start_busy: got %b want 1", busy); end
        n_tests++; if (x_pos !== 12'd100) begin n_fail++; $display("FAIL basic_start_x: got %0d want 100", x_pos); end
        n_tests++; if (y_pos !== 12'd0) begin n_fail++; $display("FAIL basic_start_y: got %0d want 0", y_pos); end
        for (int k = 1; k <= 27; k++) begin
            wait_tick();
            n_tests++; if (int'(y_pos) != exp_y(13, k)) begin n_fail++; $display("FAIL basic_y tick %0d: got %0d want %0d", k, y_pos, exp_y(13, k)); end
            n_tests++; if (int'(x_pos) != exp_x(100, 2, 0, k)) begin n_fail++; $display("FAIL basic_x tick %0d: got %0d want %0d", k, x_pos, exp_x(100, 2, 0, k)); end
            n_tests++; if (at_peak !== (k == 13)) begin n_fail++; $display("FAIL basic_peak tick %0d: got %b want %b", k, at_peak, (k == 13)); end
            n_tests++; if (done !== (k == 27)) begin n_fail++; $display("FAIL basic_done tick %0d: got %b want %b", k, done, (k == 27)); end
        end
        n_tests++; if (ymax != 91) begin n_fail++; $display("FAIL basic_peak_height: got %0d want 91", ymax); end
        n_tests++; if (peak_cnt != 1) begin n_fail++; $display("FAIL basic_peak_count: got %0d want 1", peak_cnt); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_tests++; if (busy_cnt != 108) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 108", busy_cnt); end
        n_tests++; if (x_pos !== 12'd154) begin n_fail++; $display("FAIL basic_final_x: got %0d want 154", x_pos); end
    endtask

    task automatic test_dir_neg_clamp();
        launch(13, 10, 3, 1'b1);
        for (int k = 1; k <= 27; k++) begin
            wait_tick();
            n_tests++; if (int'(y_pos) != exp_y(13, k)) begin n_fail++; $display("FAIL neg_y tick %0d: got %0d want %0d", k, y_pos, exp_y(13, k)); end
            n_tests++; if (int'(x_pos) != exp_x(10, 3, 1, k)) begin n_fail++; $display("FAIL neg_x tick %0d: got %0d want %0d", k, x_pos, exp_x(10, 3, 1, k)); end
        end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL neg_done_count: got %0d want 1", done_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL neg_final_busy: got %b want 0", busy); end
    endtask

    task automatic test_xmax_clamp();
        launch(2, 1000, 15, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            n_tests++; if (int'(x_pos) != exp_x(1000, 15, 0, k)) begin n_fail++; $display("FAIL xmax_x tick %0d: got %0d want %0d", k, x_pos, exp_x(1000, 15, 0, k)); end
            n_tests++; if (int'(y_pos) != exp_y(2, k)) begin n_fail++; $display("FAIL xmax_y tick %0d: got %0d want %0d", k, y_pos, exp_y(2, k)); end
        end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL xmax_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        launch(13, 100, 2, 1'b0);
        repeat (5) wait_tick();
        n_tests++; if (y_pos !== 12'd55) begin n_fail++; $display("FAIL abort_pre_y: got %0d want 55", y_pos); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_tests++; if (y_pos !== 12'd0) begin n_fail++; $display("FAIL abort_y: got %0d want 0", y_pos); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (x_pos !== 12'd110) begin n_fail++; $display("FAIL abort_x: got %0d want 110", x_pos); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        done_cnt = 0; busy_cnt = 0; peak_cnt = 0;
        repeat (10) wait_tick();
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        n_tests++; if (busy_cnt != 0) begin n_fail++; $display("FAIL abort_stays_idle: got %0d want 0", busy_cnt); end
        n_tests++; if (peak_cnt != 0) begin n_fail++; $display("FAIL abort_no_peak: got %0d want 0", peak_cnt); end
        v0 = 8'd5; x_start = 12'd500; x_speed = 4'd1; dir = 1'b0;
        enable = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; abort = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_enable_busy: got %b want 0", busy); end
        n_tests++; if (x_pos !== 12'd110) begin n_fail++; $display("FAIL abort_beats_enable_x: got %0d want 110", x_pos); end
    endtask

    task automatic test_enable_while_busy();
        launch(13, 100, 2, 1'b0);
        for (int k = 1; k <= 27; k++) begin
            if (k == 4 || k == 20) begin
                v0 = 8'd5; x_start = 12'd500; x_speed = 4'd9; dir = 1'b1; enable = 1'b1;
            end
            wait_tick();
            n_tests++; if (int'(y_pos) != exp_y(13, k)) begin n_fail++; $display("FAIL busy_en_y tick %0d: got %0d want %0d", k, y_pos, exp_y(13, k)); end
            n_tests++; if (int'(x_pos) != exp_x(100, 2, 0, k)) begin n_fail++; $display("FAIL busy_en_x tick %0d: got %0d want %0d", k, x_pos, exp_x(100, 2, 0, k)); end
        end
        n_tests++; if (ymax != 91) begin n_fail++; $display("FAIL busy_en_peak: got %0d want 91", ymax); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_en_done_tick27: got %b want 1", done); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_en_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_v0_zero();
        launch(0, 200, 1, 1'b0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL v0z_start_busy: got %b want 1", busy); end
        wait_tick();
        n_tests++; if (at_peak !== 1'b1) begin n_fail++; $display("FAIL v0z_peak: got %b want 1", at_peak); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL v0z_done: got %b want 1", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL v0z_busy: got %b want 0", busy); end
        n_tests++; if (ynz_cnt != 0) begin n_fail++; $display("FAIL v0z_y_nonzero_cycles: got %0d want 0", ynz_cnt); end
        n_tests++; if (x_pos !== 12'd201) begin n_fail++; $display("FAIL v0z_x: got %0d want 201", x_pos); end
        n_tests++; if (busy_cnt != 4) begin n_fail++; $display("FAIL v0z_busy_cycles: got %0d want 4", busy_cnt); end
    endtask

    task automatic test_rst_midflight();
        int ys [7] = '{3, 5, 6, 6, 5, 3, 0};
        launch(13, 100, 2, 1'b0);
        repeat (20) wait_tick();
        n_tests++; if (y_pos !== 12'd70) begin n_fail++; $display("FAIL rst_pre_y: got %0d want 70", y_pos); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (y_pos !== 12'd0) begin n_fail++; $display("FAIL rst_async_y: got %0d want 0", y_pos); end
        n_tests++; if (x_pos !== 12'd0) begin n_fail++; $display("FAIL rst_async_x: got %0d want 0", x_pos); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        launch(3, 0, 1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            wait_tick();
            n_tests++; if (int'(y_pos) != ys[k-1]) begin n_fail++; $display("FAIL rst_v3_y tick %0d: got %0d want %0d", k, y_pos, ys[k-1]); end
            n_tests++; if (at_peak !== (k == 3)) begin n_fail++; $display("FAIL rst_v3_peak tick %0d: got %b want %b", k, at_peak, (k == 3)); end
            n_tests++; if (done !== (k == 7)) begin n_fail++; $display("FAIL rst_v3_done tick %0d: got %b want %b", k, done, (k == 7)); end
        end
        n_tests++; if (x_pos !== 12'd7) begin n_fail++; $display("FAIL rst_v3_x: got %0d want 7", x_pos); end
    endtask

    initial begin
        test_reset();
        test_basic_arc();
        test_dir_neg_clamp();
        test_xmax_clamp();
        test_abort();
        test_enable_while_busy();
        test_v0_zero();
        test_rst_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/throw_arc_ctl.md
Name: throw_arc_ctl

Overview:
- Parametrised successor to the single-axis throw controller.
- Produces a 2-D ballistic arc: y_pos rises and falls under constant integer gravity; x_pos moves linearly in a selectable direction.
- Launch velocity, horizontal speed and direction are given per throw.
- Adds abort, a peak pulse, a landing pulse and a busy flag.
- Sits in the 65 MHz game-logic domain and feeds sprite position to the draw pipeline.

Parameters:
- POS_W, 12, width of x_pos/y_pos.
- V_W, 8, width of launch velocity input v0.
- TICK_DIV, 32, clk cycles per motion step (>=2).
- GRAVITY, 1, velocity decrement per step (>=1).
- X_MAX, 1023, upper clamp for x_pos.

Ports:
- clk  in  1  65 MHz clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  start pulse; sampled only in IDLE.
- abort  in  1  cancel throw; highest priority after rst.
- v0  in  V_W  unsigned launch vertical velocity; latched on start.
- x_start  in  POS_W  initial x; latched on start.
- x_speed  in  4  unsigned x step per tick; latched on start.
- dir  in  1  0 = +x, 1 = −x; latched on start.
- x_pos  out  POS_W  current x.
- y_pos  out  POS_W  current height above ground.
- busy  out  1  high in RISE/FALL.
- at_peak  out  1  one-cycle pulse on the RISE→FALL transition.
- done  out  1  one-cycle pulse on landing.

Behaviour:
- Reset:
  - x_pos = 0, y_pos = 0, busy = 0, at_peak = 0, done = 0.
  - Internal signed velocity vy (V_W+2 bits) = 0.
  - Tick counter = 0; state = IDLE.
- States: IDLE, RISE, FALL. busy is registered and equals (state != IDLE).
- IDLE:
  - On enable=1 at edge N: latch v0, x_speed and dir; x_pos←x_start; y_pos←0; vy←v0; tick counter cleared; state←RISE.
  - busy is high from edge N.
  - If v0 = 0, still enter RISE; the first tick transitions to FALL and lands.
- Tick: an internal strobe fires on every TICK_DIV-th cycle after start. The first tick is at edge N+TICK_DIV. All position/velocity updates happen only on tick.
- On each tick:
  - ynew = y_pos + vy, computed signed in POS_W+2 bits.
  - vy ← vy − GRAVITY.
  - x moves by x_speed per tick, saturating at 0 and X_MAX; it stays at the clamp for the rest of the throw.
- RISE:
  - y_pos ← min(ynew, 2^POS_W−1).
  - When the post-update vy <= 0: state←FALL and at_peak=1 for that one cycle.
- FALL:
  - If ynew <= 0: y_pos←0, state←IDLE, done=1 for one cycle, busy drops on the same edge.
  - Otherwise y_pos←ynew.
- Exact trajectory with GRAVITY=1:
  - After k ticks, y = k·v0 − k(k−1)/2.
  - Peak is v0(v0+1)/2, reached at ticks v0 and v0+1.
  - Landing is at tick 2·v0+1.
- enable while busy: ignored, with no relatch.
- abort=1 in RISE/FALL (edge-sampled):
  - y_pos←0, vy←0, state←IDLE, busy←0.
  - x_pos holds; done stays 0; at_peak stays 0.
- abort in IDLE: no effect.
- abort and enable in the same IDLE cycle: abort wins, no start.
- rst mid-flight: immediate return to all reset values.
- Inputs other than enable/abort are don't-care outside the start edge.

Decomposition:
- Package throw_pkg:
  - state enum (IDLE, RISE, FALL).
  - signed velocity typedef.
  - default constants TICK_DIV_DEF, GRAVITY_DEF, X_MAX_DEF.
- Sub-module throw_tick_gen:
  - Parametrised TICK_DIV counter with a synchronous clear on start and a one-cycle tick strobe.
  - Instantiated once.

Test Plan (TICK_DIV=4, GRAVITY=1, X_MAX=1023 unless noted):
1. enable pulse with v0=13, x_start=100, x_speed=2, dir=0 -> busy for 27 ticks (108 cycles); y_pos peaks at 91 with one at_peak pulse after tick 13; done pulses once; final y_pos=0, x_pos=154.
2. v0=13, x_start=10, x_speed=3, dir=1 -> x_pos clamps at 0 by tick 4 and holds; y trajectory identical to scenario 1.
3. abort asserted at tick 5 of a v0=13 throw -> next edge: y_pos=0, busy=0, done never pulses, x_pos unchanged.
4. Second enable pulse during flight with v0=5 -> ignored; peak still 91, landing at tick 27.
5. v0=0 -> at_peak on tick 1, done on tick 1, y_pos stays 0 throughout.
6. rst asserted asynchronously mid-FALL (between edges) -> all outputs 0 immediately. After release, enable with v0=3 -> y sequence 3,5,6,6,5,3,0; done on tick 7.
